// File: rtl/uart_dual_device.sv
// rtl/uart_dual_device.sv - two cross-wired UART endpoints sharing one full-duplex link

module uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_line
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t     r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0] r_bit, w_bit;
    logic [7:0] r_shift, w_shift;
    logic       r_par, w_par;
    logic       r_line, w_line;
    logic       r_ready, w_ready;
    logic       w_bit_end;

    assign w_bit_end = (r_cnt == CW'(CLK_DIV - 1));
    assign o_ready   = r_ready;
    assign o_line    = r_line;

    // State register; reset drops the line back to idle-high at once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_line  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_line  <= w_line;
            r_ready <= w_ready;
        end
    end

    // Next-state logic; the line value for each bit is registered at the bit boundary
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_par   = r_par;
        w_line  = r_line;
        w_ready = r_ready;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_line  = 1'b1;
                if (i_valid && r_ready) begin
                    w_state = S_START;
                    w_cnt   = '0;
                    w_shift = i_data;
                    w_par   = (^i_data) ^ (PARITY_ODD != 0);
                    w_line  = 1'b0;
                    w_ready = 1'b0;
                end
            end
            S_START: begin
                w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_bit   = '0;
                    w_line  = r_shift[0];
                end
            end
            S_DATA: begin
                w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            w_state = S_PARITY;
                            w_line  = r_par;
                        end else begin
                            w_state = S_STOP;
                            w_line  = 1'b1;
                        end
                    end else begin
                        w_shift = {1'b0, r_shift[7:1]};
                        w_line  = r_shift[1];
                        w_bit   = r_bit + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state = S_STOP;
                    w_line  = 1'b1;
                end
            end
            S_STOP: begin
                w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_line  = 1'b1;
            end
        endcase
    end
endmodule

module uart_rx #(
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_line,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_shift, w_shift;
    logic          r_par, w_par;
    logic [7:0]    r_data, w_data;
    logic          r_valid, w_valid;
    logic          r_perr, w_perr;
    logic          r_ferr, w_ferr;
    logic          r_sync, r_sync_d;
    logic          w_bit_end;

    assign w_bit_end    = (r_cnt == CW'(CLK_DIV - 1));
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;

    // Line register plus one delayed copy for falling-edge detection; both idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync   <= i_line;
            r_sync_d <= r_sync;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_par    <= w_par;
            r_data   <= w_data;
            r_valid  <= w_valid;
            r_perr   <= w_perr;
            r_ferr   <= w_ferr;
        end
    end

    // Next-state logic; a new frame needs a falling edge, so a stuck-low line never rearms
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_par   = r_par;
        w_data  = r_data;
        w_valid = 1'b0;
        w_perr  = r_perr;
        w_ferr  = r_ferr;
        case (r_state)
            S_IDLE: begin
                if (r_sync_d && !r_sync) begin
                    w_state = S_START;
                    w_cnt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == CW'(CLK_DIV / 2 - 1)) begin
                    w_cnt = '0;
                    if (r_sync) begin
                        w_state = S_IDLE;
                    end else begin
                        w_state = S_DATA;
                        w_bit   = '0;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_shift = {r_sync, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_par   = r_sync;
                    w_state = S_STOP;
                end
            end
            S_STOP: begin
                w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state = S_IDLE;
                    w_valid = 1'b1;
                    w_data  = r_shift;
                    w_perr  = (PARITY_EN != 0) &&
                              (r_par != ((^r_shift) ^ (PARITY_ODD != 0)));
                    w_ferr  = !r_sync;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end
endmodule

module uart_dual_device #(
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d0_tx_data,
    input  logic       d0_tx_valid,
    output logic       d0_tx_ready,
    output logic [7:0] d0_rx_data,
    output logic       d0_rx_valid,
    output logic       d0_rx_parity_err,
    output logic       d0_rx_frame_err,
    input  logic [7:0] d1_tx_data,
    input  logic       d1_tx_valid,
    output logic       d1_tx_ready,
    output logic [7:0] d1_rx_data,
    output logic       d1_rx_valid,
    output logic       d1_rx_parity_err,
    output logic       d1_rx_frame_err,
    output logic       line0,
    output logic       line1
);
    logic w_line0, w_line1;

    assign line0 = w_line0;
    assign line1 = w_line1;

    uart_tx #(.CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)) u_d0_tx (
        .clk(clk), .rst(rst), .i_data(d0_tx_data), .i_valid(d0_tx_valid),
        .o_ready(d0_tx_ready), .o_line(w_line0)
    );

    uart_rx #(.CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)) u_d1_rx (
        .clk(clk), .rst(rst), .i_line(w_line0), .o_data(d1_rx_data), .o_valid(d1_rx_valid),
        .o_parity_err(d1_rx_parity_err), .o_frame_err(d1_rx_frame_err)
    );

    uart_tx #(.CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)) u_d1_tx (
        .clk(clk), .rst(rst), .i_data(d1_tx_data), .i_valid(d1_tx_valid),
        .o_ready(d1_tx_ready), .o_line(w_line1)
    );

    uart_rx #(.CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)) u_d0_rx (
        .clk(clk), .rst(rst), .i_line(w_line1), .o_data(d0_rx_data), .o_valid(d0_rx_valid),
        .o_parity_err(d0_rx_parity_err), .o_frame_err(d0_rx_frame_err)
    );
endmodule

// File: tb/tb_uart_dual_device.sv
// tb/tb_uart_dual_device.sv - scoreboard bench for uart_dual_device

module tb_uart_dual_device;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0_tx_data, d1_tx_data;
    logic       d0_tx_valid, d1_tx_valid;
    logic       d0_tx_ready, d1_tx_ready;
    logic [7:0] d0_rx_data, d1_rx_data;
    logic       d0_rx_valid, d1_rx_valid;
    logic       d0_rx_parity_err, d1_rx_parity_err;
    logic       d0_rx_frame_err, d1_rx_frame_err;
    logic       line0, line1;

    logic [7:0] o_d0_tx_data, o_d1_tx_data;
    logic       o_d0_tx_valid, o_d1_tx_valid;
    logic       o_d0_tx_ready, o_d1_tx_ready;
    logic [7:0] o_d0_rx_data, o_d1_rx_data;
    logic       o_d0_rx_valid, o_d1_rx_valid;
    logic       o_d0_rx_parity_err, o_d1_rx_parity_err;
    logic       o_d0_rx_frame_err, o_d1_rx_frame_err;
    logic       o_line0, o_line1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [7:0] q_to_d1[$];
    logic [7:0] q_to_d0[$];
    int         p_d0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_dual_device #(.CLK_DIV(16), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst),
        .d0_tx_data(d0_tx_data), .d0_tx_valid(d0_tx_valid), .d0_tx_ready(d0_tx_ready),
        .d0_rx_data(d0_rx_data), .d0_rx_valid(d0_rx_valid),
        .d0_rx_parity_err(d0_rx_parity_err), .d0_rx_frame_err(d0_rx_frame_err),
        .d1_tx_data(d1_tx_data), .d1_tx_valid(d1_tx_valid), .d1_tx_ready(d1_tx_ready),
        .d1_rx_data(d1_rx_data), .d1_rx_valid(d1_rx_valid),
        .d1_rx_parity_err(d1_rx_parity_err), .d1_rx_frame_err(d1_rx_frame_err),
        .line0(line0), .line1(line1)
    );

    uart_dual_device #(.CLK_DIV(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst),
        .d0_tx_data(o_d0_tx_data), .d0_tx_valid(o_d0_tx_valid), .d0_tx_ready(o_d0_tx_ready),
        .d0_rx_data(o_d0_rx_data), .d0_rx_valid(o_d0_rx_valid),
        .d0_rx_parity_err(o_d0_rx_parity_err), .d0_rx_frame_err(o_d0_rx_frame_err),
        .d1_tx_data(o_d1_tx_data), .d1_tx_valid(o_d1_tx_valid), .d1_tx_ready(o_d1_tx_ready),
        .d1_rx_data(o_d1_rx_data), .d1_rx_valid(o_d1_rx_valid),
        .d1_rx_parity_err(o_d1_rx_parity_err), .d1_rx_frame_err(o_d1_rx_frame_err),
        .line0(o_line0), .line1(o_line1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx, input logic odd);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    // Receivers: every pulse must match the head of its scoreboard queue
    always @(negedge clk) begin
        if (!rst && d1_rx_valid) begin
            if (q_to_d1.size() == 0) check_eq("d1_unexpected_valid", 1, 0);
            else begin
                check_eq("d1_rx_data", d1_rx_data, q_to_d1.pop_front());
                check_eq("d1_parity_err", d1_rx_parity_err, 0);
                check_eq("d1_frame_err", d1_rx_frame_err, 0);
            end
        end
        if (!rst && d0_rx_valid) begin
            p_d0.push_back(cyc);
            if (q_to_d0.size() == 0) check_eq("d0_unexpected_valid", 1, 0);
            else begin
                check_eq("d0_rx_data", d0_rx_data, q_to_d0.pop_front());
                check_eq("d0_parity_err", d0_rx_parity_err, 0);
                check_eq("d0_frame_err", d0_rx_frame_err, 0);
            end
        end
    end

    task automatic send0(input logic [7:0] b, input bit expect_rx);
        int n = 0;
        @(negedge clk);
        d0_tx_data  = b;
        d0_tx_valid = 1'b1;
        while (!d0_tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_eq("d0_accept_timeout", 0, 1);
        if (expect_rx) q_to_d1.push_back(b);
        @(posedge clk);
        #1 d0_tx_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        d1_tx_data  = b;
        d1_tx_valid = 1'b1;
        while (!d1_tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_eq("d1_accept_timeout", 0, 1);
        q_to_d0.push_back(b);
        @(posedge clk);
        #1 d1_tx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q_to_d0.size() != 0 || q_to_d1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, q_to_d0.size() + q_to_d1.size(), 0);
    endtask

    initial begin
        int rdy_at;
        int n;
        logic [7:0] b;
        rst = 1'b1;
        d0_tx_data = '0; d0_tx_valid = 1'b0; d1_tx_data = '0; d1_tx_valid = 1'b0;
        o_d0_tx_data = '0; o_d0_tx_valid = 1'b0; o_d1_tx_data = '0; o_d1_tx_valid = 1'b0;

        repeat (5) @(negedge clk);
        check_eq("rst_line0", line0, 1);
        check_eq("rst_line1", line1, 1);
        check_eq("rst_rx_valid", {d0_rx_valid, d1_rx_valid}, 0);
        check_eq("rst_tx_ready", {d0_tx_ready, d1_tx_ready}, 0);
        check_eq("rst_rx_data", {d0_rx_data, d1_rx_data}, 0);
        check_eq("rst_err_flags", {d0_rx_parity_err, d0_rx_frame_err, d1_rx_parity_err, d1_rx_frame_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", {d0_tx_ready, d1_tx_ready}, 2'b11);

        // 0xA5 waveform on line0 at each bit midpoint, then ready latency
        b = 8'hA5;
        send0(b, 1);
        rdy_at = 0;
        for (int k = 1; k <= 180; k++) begin
            @(negedge clk);
            if (k % 16 == 8 && k / 16 < 11)
                check_eq($sformatf("a5_bit%0d", k / 16), line0, frame_bit(b, k / 16, 1'b0));
            if (d0_tx_ready && rdy_at == 0) rdy_at = k;
        end
        check_eq("a5_ready_latency", rdy_at, 177);
        drain("a5_drain");

        // Full duplex in the same cycle
        fork
            send0(8'h3C, 1);
            send1(8'hC3);
        join
        drain("duplex_drain");

        // Back-to-back from d1: second accept lands on the first ready cycle
        p_d0.delete();
        send1(8'h00);
        send1(8'hFF);
        drain("b2b_drain");
        check_eq("b2b_pulse_count", p_d0.size(), 2);
        if (p_d0.size() == 2) check_eq("b2b_pulse_spacing", p_d0[1] - p_d0[0], 177);

        // Reset mid-frame: line returns high, no pulse, next frame clean
        b = 8'h5A;
        send0(b, 0);
        repeat (59) @(negedge clk);
        check_eq("mid_line_before_rst", line0, frame_bit(b, 3, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_line0_after_rst", line0, 1);
        check_eq("mid_ready_after_rst", d0_tx_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        send0(8'h96, 1);
        drain("post_rst_drain");

        // Odd parity instance: 0x01 carries parity bit 0
        @(negedge clk);
        o_d0_tx_data  = 8'h01;
        o_d0_tx_valid = 1'b1;
        n = 0;
        while (!o_d0_tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("odd_accept", o_d0_tx_ready, 1);
        @(posedge clk);
        #1 o_d0_tx_valid = 1'b0;
        for (int k = 1; k <= 152; k++) begin
            @(negedge clk);
            if (k == 152) check_eq("odd_parity_bit", o_line0, frame_bit(8'h01, 9, 1'b1));
        end
        n = 0;
        while (!o_d1_rx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("odd_rx_valid", o_d1_rx_valid, 1);
        check_eq("odd_rx_data", o_d1_rx_data, 8'h01);
        check_eq("odd_rx_errs", {o_d1_rx_parity_err, o_d1_rx_frame_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
